temp_scan_ctrl: RTL and testbench

//  Round-robin scan scheduler sharing one F_to_C converter and one alarm comparator among N_SENS sensors.

---
 rtl/temp_scan_if.sv | 21 ++
 rtl/temp_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_temp_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temp_scan_if.sv
// Sensor sample handshake plus the shared F_to_C converter bus.
// master = scan controller, slave = sensor front-ends / converter side.
interface temp_scan_if #(
  parameter int N_SENS = 4
) ();
  logic [N_SENS-1:0] smp_req;
  logic              smp_vld;
  logic [7:0]        smp_data;
  logic [7:0]        conv_temp_f;
  logic [7:0]        conv_celsius;

  modport master (
    output smp_req, conv_temp_f,
    input  smp_vld, smp_data, conv_celsius
  );

  modport slave (
    input  smp_req, conv_temp_f,
    output smp_vld, smp_data, conv_celsius
  );
endinterface

// File: rtl/temp_scan_ctrl.sv
// Round-robin temperature scan: requests each sensor in turn, pushes the
// sample through one shared F_to_C converter, then applies a debounced,
// hysteretic over-temperature alarm and a per-sensor timeout fault.
module temp_scan_ctrl #(
  parameter  int N_SENS   = 4,
  parameter  int CONV_LAT = 1,
  parameter  int ALARM_HI = 57,
  parameter  int ALARM_LO = 52,
  parameter  int DEBOUNCE = 3,
  parameter  int TIMEOUT  = 15,
  localparam int IW       = $clog2(N_SENS),
  localparam int CW       = $clog2(DEBOUNCE + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  temp_scan_if.master       bus,
  output logic [IW-1:0]     cur_idx,
  output logic [N_SENS-1:0] alarm,
  output logic              any_alarm,
  output logic [N_SENS-1:0] fault,
  output logic              scan_done
);

  typedef enum logic [2:0] {IDLE, REQ, CONV, EVAL, NEXT} state_t;

  localparam logic [IW-1:0] LAST      = IW'(N_SENS - 1);
  localparam logic [7:0]    TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [2:0]    CONV_LAST = 3'(CONV_LAT - 1);
  localparam logic [7:0]    HI        = 8'(ALARM_HI);
  localparam logic [7:0]    LO        = 8'(ALARM_LO);
  localparam logic [CW-1:0] DB        = CW'(DEBOUNCE);

  state_t                       state, nxt;
  logic [IW-1:0]                idx, idx_nxt;
  logic [7:0]                   tcnt;
  logic [2:0]                   ccnt;
  logic [7:0]                   cel_q;
  logic [N_SENS-1:0][CW-1:0]    cnt, cnt_nxt;
  logic [N_SENS-1:0]            alarm_nxt, fault_nxt, req_nxt;
  logic                         to_hit, conv_end;

  assign to_hit   = (tcnt == TO_LAST);
  assign conv_end = (ccnt == CONV_LAST);
  assign cur_idx  = idx;

  // State and sensor index register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state / next index; en only matters in IDLE and at pass wrap.
  always_comb begin
    nxt     = state;
    idx_nxt = idx;
    case (state)
      IDLE: if (en) begin
        idx_nxt = '0;
        nxt     = REQ;
      end
      REQ: begin
        if (bus.smp_vld)  nxt = CONV;
        else if (to_hit)  nxt = NEXT;
      end
      CONV: if (conv_end) nxt = EVAL;
      EVAL: nxt = NEXT;
      NEXT: begin
        if (idx == LAST) begin
          idx_nxt = '0;
          nxt     = en ? REQ : IDLE;
        end else begin
          idx_nxt = idx + 1'b1;
          nxt     = REQ;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Registered one-hot request, valid for exactly the REQ cycles.
  always_comb begin
    req_nxt = '0;
    if (nxt == REQ) req_nxt[idx_nxt] = 1'b1;
  end

  // Per-sensor debounce/hysteresis and fault update for the serviced sensor.
  always_comb begin
    cnt_nxt   = cnt;
    alarm_nxt = alarm;
    fault_nxt = fault;
    if (state == REQ && !bus.smp_vld && to_hit) fault_nxt[idx] = 1'b1;
    if (state == EVAL) begin
      fault_nxt[idx] = 1'b0;
      if (cel_q > HI) begin
        if (cnt[idx] != DB) cnt_nxt[idx] = cnt[idx] + 1'b1;
        if (cnt_nxt[idx] == DB) alarm_nxt[idx] = 1'b1;
      end else if (cel_q < LO) begin
        cnt_nxt[idx]   = '0;
        alarm_nxt[idx] = 1'b0;
      end else begin
        cnt_nxt[idx] = '0;
      end
    end
  end

  // Wait counters, datapath capture and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tcnt            <= '0;
      ccnt            <= '0;
      cel_q           <= '0;
      cnt             <= '0;
      alarm           <= '0;
      any_alarm       <= 1'b0;
      fault           <= '0;
      scan_done       <= 1'b0;
      bus.smp_req     <= '0;
      bus.conv_temp_f <= '0;
    end else begin
      tcnt <= (state == REQ)  ? tcnt + 8'd1 : '0;
      ccnt <= (state == CONV) ? ccnt + 3'd1 : '0;
      if (state == REQ && bus.smp_vld) bus.conv_temp_f <= bus.smp_data;
      if (state == CONV && conv_end)   cel_q <= bus.conv_celsius;
      cnt         <= cnt_nxt;
      alarm       <= alarm_nxt;
      any_alarm   <= |alarm_nxt;
      fault       <= fault_nxt;
      bus.smp_req <= req_nxt;
      scan_done   <= (state == NEXT) && (idx == LAST);
    end
  end

endmodule

// File: tb/tb_temp_scan_ctrl.sv
// Bench for temp_scan_ctrl: sensor responder + F_to_C model, a table of
// scan passes with hand-computed results, hand sequences for en-drop and
// mid-conversion reset, then randomized passes against a per-pass model.
module tb_temp_scan_ctrl;
  localparam int N        = 4;
  localparam int CONV_LAT = 1;
  localparam int TIMEOUT  = 15;

  logic clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [1:0]   cur_idx;
  logic [N-1:0] alarm, fault;
  logic         any_alarm, scan_done;

  temp_scan_if #(.N_SENS(N)) bus ();

  temp_scan_ctrl #(.N_SENS(N), .CONV_LAT(CONV_LAT), .ALARM_HI(57), .ALARM_LO(52),
                   .DEBOUNCE(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .en(en), .bus(bus), .cur_idx(cur_idx),
    .alarm(alarm), .any_alarm(any_alarm), .fault(fault), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] f2c(input logic [7:0] f);
    if (f < 8'd32) return 8'd0;
    return 8'(((int'(f) - 32) * 5) / 9);
  endfunction

  assign bus.conv_celsius = f2c(bus.conv_temp_f);

  // Sensor configuration for the pass in flight, and model state.
  logic [N-1:0][7:0] cfg_f;
  logic [N-1:0]      cfg_ok;
  int                cfg_dly[N];
  int                m_cnt[N];
  logic [N-1:0]      m_alarm, m_fault;
  int                req_log[$];
  int                errors = 0, checks = 0;

  typedef struct {
    logic [N-1:0][7:0] f;
    logic [N-1:0]      ok;
    logic [N-1:0]      alarm;
    logic [N-1:0]      fault;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sensor front-ends: answer dly cycles after the request is first seen.
  initial begin
    logic [N-1:0] prev;
    int seen, s;
    prev = '0; seen = 0;
    bus.smp_vld = 1'b0; bus.smp_data = '0;
    forever begin
      @(posedge clk); #2;
      if (bus.smp_req != '0) begin
        s = 0;
        for (int i = N - 1; i >= 0; i--) if (bus.smp_req[i]) s = i;
        if (bus.smp_req !== prev) begin
          seen = 0;
          req_log.push_back(s);
        end
        seen++;
        if (cfg_ok[s] && seen > cfg_dly[s]) begin
          bus.smp_vld = 1'b1; bus.smp_data = cfg_f[s];
        end else begin
          bus.smp_vld = 1'b0; bus.smp_data = 8'($urandom);
        end
      end else begin
        bus.smp_vld = 1'b0; bus.smp_data = 8'($urandom);
      end
      prev = bus.smp_req;
    end
  end

  // Expected cycles per full pass for the current configuration.
  function automatic int exp_period();
    int p = 0;
    for (int s = 0; s < N; s++)
      p += cfg_ok[s] ? (cfg_dly[s] + 1 + CONV_LAT + 2) : (TIMEOUT + 1);
    return p;
  endfunction

  // Alarm/fault rules applied to one whole pass.
  task automatic model_pass();
    int c;
    for (int s = 0; s < N; s++) begin
      if (!cfg_ok[s]) m_fault[s] = 1'b1;
      else begin
        m_fault[s] = 1'b0;
        c = int'(f2c(cfg_f[s]));
        if (c > 57) begin
          if (m_cnt[s] < 3) m_cnt[s]++;
          if (m_cnt[s] == 3) m_alarm[s] = 1'b1;
        end else if (c < 52) begin
          m_cnt[s] = 0; m_alarm[s] = 1'b0;
        end else m_cnt[s] = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < N; s++) m_cnt[s] = 0;
    m_alarm = '0; m_fault = '0;
  endtask

  task automatic wait_done(output int cyc, output bit got);
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (scan_done) got = 1'b1;
    end
  endtask

  task automatic run_pass(input string nm, input bit chk_per);
    int per, cyc;
    bit got;
    logic [31:0] lc, le;
    per = exp_period();
    model_pass();
    wait_done(cyc, got);
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s.timeout: no scan_done in 1000 cycles, expected one", nm);
      req_log.delete();
      return;
    end
    check({nm, ".alarm"}, 32'(alarm), 32'(m_alarm));
    check({nm, ".fault"}, 32'(fault), 32'(m_fault));
    check({nm, ".any"},   32'(any_alarm), 32'(|m_alarm));
    if (chk_per) check({nm, ".period"}, cyc, per);
    lc = req_log.size(); le = N;
    foreach (req_log[i]) lc = lc * 16 + 32'(req_log[i]);
    for (int i = 0; i < N; i++) le = le * 16 + 32'(i);
    check({nm, ".order"}, lc, le);
    req_log.delete();
  endtask

  task automatic randomize_cfg();
    int r;
    for (int s = 0; s < N; s++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: cfg_f[s] = 8'd125;
        1: cfg_f[s] = 8'd126;
        2: cfg_f[s] = 8'd136;
        3: cfg_f[s] = 8'd137;
        4: cfg_f[s] = 8'($urandom_range(137, 220));
        default: cfg_f[s] = 8'($urandom_range(32, 135));
      endcase
      cfg_ok[s]  = ($urandom_range(0, 7) != 0);
      cfg_dly[s] = $urandom_range(0, 3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    bit found;
    int busy;
    // Per-sensor F values are listed s3,s2,s1,s0; masks are {s3,s2,s1,s0}.
    tbl[0]  = '{f:{8'd100, 8'd100, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[1]  = '{f:{8'd100, 8'd140, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[2]  = '{f:{8'd100, 8'd100, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[3]  = '{f:{8'd100, 8'd140, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[4]  = '{f:{8'd100, 8'd140, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[5]  = '{f:{8'd100, 8'd140, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0100, fault:4'b0000};
    tbl[6]  = '{f:{8'd100, 8'd130, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0100, fault:4'b0000};
    tbl[7]  = '{f:{8'd100, 8'd122, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[8]  = '{f:{8'd100, 8'd100, 8'd100, 8'd100}, ok:4'b1101, alarm:4'b0000, fault:4'b0010};
    tbl[9]  = '{f:{8'd100, 8'd100, 8'd100, 8'd100}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[10] = '{f:{8'd140, 8'd100, 8'd100, 8'd140}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[11] = '{f:{8'd140, 8'd100, 8'd100, 8'd140}, ok:4'b1111, alarm:4'b0000, fault:4'b0000};
    tbl[12] = '{f:{8'd140, 8'd100, 8'd100, 8'd140}, ok:4'b1111, alarm:4'b1001, fault:4'b0000};
    tbl[13] = '{f:{8'd50,  8'd100, 8'd100, 8'd130}, ok:4'b1111, alarm:4'b0001, fault:4'b0000};
    tbl[14] = '{f:{8'd100, 8'd100, 8'd100, 8'd100}, ok:4'b1110, alarm:4'b0001, fault:4'b0001};

    for (int s = 0; s < N; s++) cfg_dly[s] = 1;
    cfg_ok = '0; cfg_f = '0;
    model_reset();

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check("por.req",   32'(bus.smp_req), 0);
    check("por.alarm", 32'(alarm), 0);
    check("por.fault", 32'(fault), 0);
    check("por.any",   32'(any_alarm), 0);
    check("por.done",  32'(scan_done), 0);
    check("por.idx",   32'(cur_idx), 0);
    rstn = 1'b1;

    // Table of passes: sequencing, debounce, hysteresis, timeout.
    for (int r = 0; r < 15; r++) begin
      cfg_f = tbl[r].f; cfg_ok = tbl[r].ok;
      if (r == 0) en = 1'b1;
      run_pass($sformatf("tbl%0d", r), r != 0);
      check($sformatf("tbl%0d.alarm_tbl", r), 32'(alarm), 32'(tbl[r].alarm));
      check($sformatf("tbl%0d.fault_tbl", r), 32'(fault), 32'(tbl[r].fault));
    end

    // en dropped while sensor 1 is being requested: pass still completes.
    cfg_f = {8'd130, 8'd130, 8'd130, 8'd130}; cfg_ok = 4'b1101;
    fork
      begin
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
          @(posedge clk); #1;
          if (bus.smp_req[1]) begin en = 1'b0; hit = 1'b1; end
        end
      end
    join_none
    run_pass("endrop", 1'b1);
    check("endrop.en", 32'(en), 0);
    check("endrop.alarm_tbl", 32'(alarm), 32'h1);
    check("endrop.fault_tbl", 32'(fault), 32'h2);
    busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.smp_req != '0 || scan_done) busy++;
    end
    check("endrop.idle", busy, 0);
    check("endrop.noreq", req_log.size(), 0);

    // Reset asserted for 2 cycles while sensor 0 is in conversion.
    cfg_f = {8'd100, 8'd100, 8'd100, 8'd100}; cfg_ok = 4'b1111;
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.smp_vld) found = 1'b1;
    end
    check("rst.reached_conv", 32'(found), 1);
    check("rst.pre_alarm", 32'(alarm), 32'h1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst.req",   32'(bus.smp_req), 0);
    check("rst.alarm", 32'(alarm), 0);
    check("rst.fault", 32'(fault), 0);
    check("rst.any",   32'(any_alarm), 0);
    check("rst.done",  32'(scan_done), 0);
    check("rst.idx",   32'(cur_idx), 0);
    check("rst.convf", 32'(bus.conv_temp_f), 0);
    en = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.smp_req != '0 || scan_done || alarm != '0) busy++;
    end
    check("rst.idle", busy, 0);
    model_reset();
    req_log.delete();

    // Randomized passes checked against the pass-level model.
    randomize_cfg();
    en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      run_pass($sformatf("rnd%0d", p), p != 0);
      randomize_cfg();
    end
    en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
